// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter
//   Single-port video RAM scheduler. Pixel strobes in the visible region get a
//   guaranteed display read. All other cycles are offered to host writes. Read
//   data comes back as a registered pixel word two clocks after the strobe.
//   Scan-out is held off until the first frame wrap after reset, so the display
//   always starts on a clean frame boundary.
//
//   Build option: define VRAM_BLANK_ONLY_EN to restrict host writes to the
//   blanking interval (tear-free updates). When it is undefined, writes may
//   interleave with scan-out in any cycle without a display strobe.
//
//   Ports
//     clk, rst          : clock, asynchronous active-low reset
//     pix_clk           : one-clk pixel strobe from the pixel iterator
//     draw_active       : iterator is inside the visible region
//     pix_x, pix_y      : iterator column / row
//     draw_end          : last visible line done (echoed as vblank_evt)
//     screen_end        : frame wrap
//     host_req/addr/wdata, host_gnt : host write port, accept = req & gnt
//     host_err          : sticky, an accepted write was out of range
//     mem_en/we/addr/wdata, mem_rdata : registered single-port RAM interface
//     pix_data, pix_valid : pixel word to the DAC stage
//     frame_cnt         : frames scanned since reset (mod 256)
module vram_scan_arbiter #(
  parameter int H_OFFSET = 160,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int DW       = 8,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_clk,
  input  logic          draw_active,
  input  logic [9:0]    pix_x,
  input  logic [8:0]    pix_y,
  input  logic          draw_end,
  input  logic          screen_end,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_err,
  output logic          vblank_evt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic [7:0]    frame_cnt
);

  // One extra bit so the pixel count itself is representable for the compare.
  localparam logic [AW:0] PIX_TOTAL = (AW+1)'(H_RES * V_RES);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    SCAN      = 1'b1
  } state_e;

  state_e        state_q;
  logic          host_err_q;
  logic          vblank_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rd_pend_q;   // a display read was presented to the RAM last cycle
  logic [DW-1:0] pix_data_q;
  logic          pix_valid_q;
  logic [7:0]    frame_cnt_q;

  logic          disp_sel;
  logic          host_acc;
  logic          host_in_range;
  logic [AW-1:0] disp_addr;

  assign disp_sel = pix_clk & draw_active & (state_q == SCAN);

  // Linear frame-buffer address; the constant multiply reduces to shifts/adds.
  assign disp_addr = AW'(pix_y) * AW'(H_RES) + AW'(pix_x) - AW'(H_OFFSET);

`ifdef VRAM_BLANK_ONLY_EN
  assign host_gnt = host_req & ~draw_active & ~disp_sel;
`else
  assign host_gnt = host_req & ~disp_sel;
`endif

  assign host_acc      = host_req & host_gnt;
  assign host_in_range = ({1'b0, host_addr} < PIX_TOTAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SYNC_WAIT;
      host_err_q  <= 1'b0;
      vblank_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vblank_q <= draw_end;

      // Frame alignment: the wrap that starts scanning is not counted.
      case (state_q)
        SYNC_WAIT: if (screen_end) state_q <= SCAN;
        SCAN:      if (screen_end) frame_cnt_q <= frame_cnt_q + 8'd1;
        default:   state_q <= SYNC_WAIT;
      endcase

      // RAM command slot. Address/data hold when the slot is idle.
      if (disp_sel) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= disp_addr;
      end else if (host_acc && host_in_range) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= host_addr;
        mem_wdata_q <= host_wdata;
      end else begin
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end

      // An out-of-range write is still acknowledged but dropped.
      if (host_acc && !host_in_range) host_err_q <= 1'b1;

      // Read pipeline: the RAM samples the read one edge after it is issued and
      // its data is captured on the following edge.
      rd_pend_q   <= mem_en_q & ~mem_we_q;
      pix_valid_q <= rd_pend_q;
      if (rd_pend_q) pix_data_q <= mem_rdata;
    end
  end

  assign host_err   = host_err_q;
  assign vblank_evt = vblank_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
module tb_vram_scan_arbiter;

  localparam int H_OFFSET = 160;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int DW       = 8;
  localparam int AW       = 19;
  localparam int RAM_N    = 1 << AW;
  localparam int TOTAL    = H_RES * V_RES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_clk = 1'b0;
  logic          draw_active = 1'b0;
  logic [9:0]    pix_x = '0;
  logic [8:0]    pix_y = '0;
  logic          draw_end = 1'b0;
  logic          screen_end = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt;
  logic          host_err;
  logic          vblank_evt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  vram_scan_arbiter #(
    .H_OFFSET(H_OFFSET), .H_RES(H_RES), .V_RES(V_RES), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_clk(pix_clk), .draw_active(draw_active),
    .pix_x(pix_x), .pix_y(pix_y), .draw_end(draw_end), .screen_end(screen_end),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_err(host_err), .vblank_evt(vblank_evt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_cnt(frame_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] init_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- environment RAM (responds to the DUT) ----------------
  logic [7:0] ram [0:RAM_N-1];
  initial begin
    for (int i = 0; i < RAM_N; i++) ram[i] = init_f(AW'(i));
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; logic [7:0] d; } pend_t;
  pend_t      pq[$];
  logic [7:0] shadow [0:RAM_N-1];
  bit         m_scan, m_err, m_vblank, m_en, m_we, m_pv;
  int         m_addr, m_wdata, m_pd, m_frame, cyc;

  function automatic bit m_gnt();
    bit g;
    g = host_req && !(pix_clk && draw_active && m_scan);
`ifdef VRAM_BLANK_ONLY_EN
    g = g && !draw_active;
`endif
    return g;
  endfunction

  initial begin
    bit disp, acc;
    int a;
    pend_t p;
    m_scan = 0; m_err = 0; m_vblank = 0; m_en = 0; m_we = 0; m_pv = 0;
    m_addr = 0; m_wdata = 0; m_pd = 0; m_frame = 0; cyc = 0;
    for (int i = 0; i < RAM_N; i++) shadow[i] = init_f(AW'(i));
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_scan = 0; m_err = 0; m_vblank = 0; m_en = 0; m_we = 0; m_pv = 0;
        m_addr = 0; m_wdata = 0; m_pd = 0; m_frame = 0; cyc = 0;
        pq.delete();
      end else begin
        cyc++;
        disp = pix_clk && draw_active && m_scan;
        acc  = m_gnt();
        m_vblank = draw_end;
        if (screen_end) begin
          if (m_scan) m_frame = (m_frame + 1) % 256;
          else m_scan = 1;
        end
        m_pv = 0;
        while (pq.size() > 0 && pq[0].due == cyc) begin
          m_pv = 1;
          m_pd = pq[0].d;
          void'(pq.pop_front());
        end
        if (disp) begin
          a = (int'(pix_y) * H_RES + int'(pix_x) - H_OFFSET) & (RAM_N - 1);
          m_en = 1; m_we = 0; m_addr = a;
          p.due = cyc + 2; p.d = shadow[a];
          pq.push_back(p);
        end else if (acc && int'(host_addr) < TOTAL) begin
          m_en = 1; m_we = 1; m_addr = int'(host_addr); m_wdata = int'(host_wdata);
          shadow[host_addr] = host_wdata;
        end else begin
          m_en = 0; m_we = 0;
        end
        if (acc && int'(host_addr) >= TOTAL) m_err = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("cyc_host_gnt",   32'(host_gnt),   32'(m_gnt()));
    chk("cyc_host_err",   32'(host_err),   32'(m_err));
    chk("cyc_vblank",     32'(vblank_evt), 32'(m_vblank));
    chk("cyc_mem_en",     32'(mem_en),     32'(m_en));
    chk("cyc_mem_we",     32'(mem_we),     32'(m_we));
    chk("cyc_mem_addr",   32'(mem_addr),   32'(m_addr));
    chk("cyc_mem_wdata",  32'(mem_wdata),  32'(m_wdata));
    chk("cyc_pix_valid",  32'(pix_valid),  32'(m_pv));
    chk("cyc_pix_data",   32'(pix_data),   32'(m_pd));
    chk("cyc_frame_cnt",  32'(frame_cnt),  32'(m_frame));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit last_acc, last_req;
    repeat (3) step();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_host_err", 32'(host_err), 0);
    rst = 1'b1;
    step();

    // strobe before frame sync must not read
    draw_active = 1; pix_clk = 1; pix_x = 10'd160; pix_y = 9'd1;
    step();
    pix_clk = 0; draw_active = 0;
    chk("nosync_mem_en", 32'(mem_en), 0);

    screen_end = 1; step(); screen_end = 0;
    chk("sync_frame0", 32'(frame_cnt), 0);
    screen_end = 1; step(); screen_end = 0;
    chk("sync_frame1", 32'(frame_cnt), 1);

    // basic display read at (160,1) -> address 640
    draw_active = 1; pix_clk = 1; pix_x = 10'd160; pix_y = 9'd1;
    step();
    pix_clk = 0; draw_active = 0;
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 640);
    step();
    chk("rd_pv_early", 32'(pix_valid), 0);
    step();
    chk("rd_pix_valid", 32'(pix_valid), 1);
    chk("rd_pix_data", 32'(pix_data), 32'h82);
    step();
    chk("rd_pv_one", 32'(pix_valid), 0);
    chk("rd_pd_hold", 32'(pix_data), 32'h82);

    // collision: display wins, host served next clk
    draw_active = 1; pix_clk = 1; pix_x = 10'd161; pix_y = 9'd1;
    host_req = 1; host_addr = 19'd5; host_wdata = 8'hAA;
    #1 chk("col_gnt0", 32'(host_gnt), 0);
    step();
    pix_clk = 0; draw_active = 0;
    #1 chk("col_gnt1", 32'(host_gnt), 1);
    chk("col_rd_addr", 32'(mem_addr), 641);
    step();
    host_req = 0;
    chk("col_we", 32'(mem_we), 1);
    chk("col_addr", 32'(mem_addr), 5);
    chk("col_wdata", 32'(mem_wdata), 32'hAA);
    step();
    chk("col_pix_data", 32'(pix_data), 32'h83);
    chk("idle_en", 32'(mem_en), 0);
    chk("idle_addr_hold", 32'(mem_addr), 5);

    // write then read the same pixel
    host_req = 1; host_addr = 19'd642; host_wdata = 8'h5C;
    step();
    host_req = 0;
    draw_active = 1; pix_clk = 1; pix_x = 10'd162; pix_y = 9'd1;
    step();
    pix_clk = 0; draw_active = 0;
    step(); step();
    chk("raw_pix_valid", 32'(pix_valid), 1);
    chk("raw_pix_data", 32'(pix_data), 32'h5C);

    // last visible pixel
    draw_active = 1; pix_clk = 1; pix_x = 10'd799; pix_y = 9'd479;
    step();
    pix_clk = 0; draw_active = 0;
    chk("last_addr", 32'(mem_addr), 307199);
    step(); step();

    // out-of-range host write
    host_req = 1; host_addr = 19'd307200; host_wdata = 8'h11;
    #1 chk("oor_gnt", 32'(host_gnt), 1);
    step();
    host_req = 0;
    chk("oor_mem_en", 32'(mem_en), 0);
    chk("oor_err", 32'(host_err), 1);
    repeat (3) step();
    chk("oor_err_sticky", 32'(host_err), 1);

    // vblank echo
    draw_end = 1; step(); draw_end = 0;
    chk("vblank_on", 32'(vblank_evt), 1);
    step();
    chk("vblank_off", 32'(vblank_evt), 0);

    // host request during the visible region without a strobe
    draw_active = 1; pix_clk = 0; host_req = 1; host_addr = 19'd10; host_wdata = 8'h03;
`ifdef VRAM_BLANK_ONLY_EN
    #1 chk("blank_gnt_blocked", 32'(host_gnt), 0);
    step();
    chk("blank_gnt_still", 32'(host_gnt), 0);
    draw_active = 0;
    #1 chk("blank_gnt_free", 32'(host_gnt), 1);
    step();
`else
    #1 chk("active_gnt", 32'(host_gnt), 1);
    step();
`endif
    host_req = 0; draw_active = 0;
    chk("act_we", 32'(mem_we), 1);
    chk("act_addr", 32'(mem_addr), 10);
    chk("act_wdata", 32'(mem_wdata), 3);

    // mixed traffic, checked by the per-cycle model
    last_acc = 0; last_req = 0;
    for (int i = 0; i < 60; i++) begin
      if (last_acc || !last_req) begin
        host_addr  = AW'(640 + (i * 7) % 32);
        host_wdata = 8'(i * 13 + 1);
      end
      pix_clk     = (i % 3 != 2);
      draw_active = (i % 20 < 14);
      pix_x       = 10'(160 + i % 8);
      pix_y       = 9'((i / 8) % 4);
      host_req    = (i % 5 != 0);
      #1;
      last_req = host_req;
      last_acc = host_req && host_gnt;
      step();
    end
    pix_clk = 0; draw_active = 0; host_req = 0;
    repeat (3) step();

    // frame counter wrap: currently 1, +255 -> 0
    screen_end = 1;
    repeat (254) step();
    chk("frame_255", 32'(frame_cnt), 255);
    step();
    screen_end = 0;
    chk("frame_wrap", 32'(frame_cnt), 0);
    screen_end = 1; step(); screen_end = 0;
    chk("frame_after_wrap", 32'(frame_cnt), 1);

    // asynchronous reset right after a display read is issued
    draw_active = 1; pix_clk = 1; pix_x = 10'd163; pix_y = 9'd2;
    step();
    pix_clk = 0; draw_active = 0;
    chk("ar_mem_en_pre", 32'(mem_en), 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_mem_en", 32'(mem_en), 0);
    chk("ar_frame", 32'(frame_cnt), 0);
    chk("ar_err", 32'(host_err), 0);
    step();
    chk("ar_pv1", 32'(pix_valid), 0);
    step();
    chk("ar_pv2", 32'(pix_valid), 0);
    rst = 1'b1;
    step();
    chk("ar_pv3", 32'(pix_valid), 0);
    draw_active = 1; pix_clk = 1; pix_x = 10'd160; pix_y = 9'd0;
    step();
    pix_clk = 0; draw_active = 0;
    chk("ar_no_read", 32'(mem_en), 0);
    screen_end = 1; step(); screen_end = 0;
    draw_active = 1; pix_clk = 1; pix_x = 10'd161; pix_y = 9'd0;
    step();
    pix_clk = 0; draw_active = 0;
    chk("ar_read_again", 32'(mem_en), 1);
    chk("ar_read_addr", 32'(mem_addr), 1);
    step(); step();
    chk("ar_read_data", 32'(pix_data), 32'h01);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_scan_arbiter.md
# vram_scan_arbiter

Single-port video RAM scheduler between the pixel iterator and the host write port. Each pixel strobe inside the active region gets a guaranteed display read. All remaining clock cycles are granted to host writes. Read data is returned as a registered pixel word for the DAC stage. The block also tracks frame alignment, so scan-out only starts on a clean frame boundary.

## Interface
Parameters:
- H_OFFSET, 160: pix_x value of the first visible column
- H_RES, 640: visible columns
- V_RES, 480: visible rows
- DW, 8: pixel data width
- AW, 19: memory address width; must satisfy 2^AW >= H_RES*V_RES

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pix_clk  in  1  one-clk pixel strobe from the pixel iterator
- draw_active  in  1  iterator is in the visible region
- pix_x  in  10  iterator column; valid range H_OFFSET..H_OFFSET+H_RES-1 while draw_active
- pix_y  in  9  iterator row
- draw_end  in  1  last visible line completed
- screen_end  in  1  frame wrap
- host_req  in  1  host write request
- host_addr  in  AW  host pixel address
- host_wdata  in  DW  host pixel data
- host_gnt  out  1  combinational; a write is accepted on a clk edge where host_req & host_gnt
- host_err  out  1  sticky: an accepted write had host_addr >= H_RES*V_RES
- vblank_evt  out  1  one-clk pulse after draw_end
- mem_en  out  1  registered memory enable
- mem_we  out  1  registered write enable
- mem_addr  out  AW  registered memory address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  read data, valid one clk after mem_en & !mem_we
- pix_data  out  DW  pixel to DAC
- pix_valid  out  1  one-clk pulse, pix_data updated
- frame_cnt  out  8  frames scanned since reset, wraps at 255

## Operation
- Frame FSM, two states:
  - SYNC_WAIT: reset state; no display reads.
  - SYNC_WAIT -> SCAN on screen_end.
  - SCAN stays until reset.
- disp_sel = pix_clk & draw_active & (state==SCAN).
- Display read address: pix_y*H_RES + (pix_x - H_OFFSET), computed in AW bits. For H_RES=640 this is (pix_y<<9)+(pix_y<<7).
- Arbitration: host_gnt = host_req & !disp_sel. The display always wins a collision.
- Accepted write: next cycle drives mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata.
- Out-of-range write: host_gnt is still issued, mem_en stays 0, and host_err sets. host_err clears only on reset.
- Idle cycle (no disp_sel, no accepted write): mem_en=0, mem_we=0. mem_addr and mem_wdata hold their values.
- frame_cnt increments on each screen_end seen in SCAN. The screen_end that causes SYNC_WAIT->SCAN does not increment it.
- vblank_evt is the registered copy of draw_end, in either state.

## Timing
- Reset values: all outputs 0, state SYNC_WAIT. Async assertion mid-transfer kills any pending pix_valid and mem_en immediately.
- Display latency is 2 clk:
  - Edge E0 samples disp_sel, so mem_en=1, mem_we=0 after E0.
  - The memory samples at E1 and mem_rdata is valid after E1.
  - pix_data=mem_rdata and pix_valid=1 after E2, for one clk.
- pix_data holds its value between pulses and is not cleared in blanking.
- Host write latency is 1 clk from the accepting edge to mem_en.
- Back-to-back host writes are allowed every clk in which disp_sel=0.
- Host must hold host_addr and host_wdata stable until accepted.
- With pix_clk asserted every clk during draw_active, the host is starved in the active region. This is permitted; the host is served in blanking.

## Configuration
- VRAM_BLANK_ONLY_EN defined: host_gnt = host_req & !draw_active & !disp_sel. Writes happen only in blanking, for tear-free updates.
- VRAM_BLANK_ONLY_EN undefined: the arbitration above applies; writes may interleave with scan-out.

## Test plan
- Reset, then pulse screen_end once: state SCAN, frame_cnt=0. A second screen_end gives frame_cnt=1.
- In SCAN, pix_clk strobe with draw_active=1, pix_x=160, pix_y=1: mem_en=1, mem_we=0, mem_addr=640 one clk later. pix_valid pulses 2 clk after the strobe with pix_data=mem_rdata.
- host_req in the same clk as the display strobe (host_addr=5, host_wdata=0xAA): host_gnt=0 in that clk. Next clk host_gnt=1, and the clk after that shows mem_we=1, mem_addr=5, mem_wdata=0xAA.
- Host write to address 307200: host_gnt=1, no mem_en, host_err=1 and stays 1 until rst=0.
- With VRAM_BLANK_ONLY_EN defined, host_req held with draw_active=1: host_gnt=0 until draw_active=0, then granted in that clk.
- Assert rst=0 one clk after a display read is issued: pix_valid never pulses, mem_en=0 immediately, state SYNC_WAIT. No reads occur until the next screen_end.
